univ_shift_reg: RTL and testbench

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg.sv | 115 +++++++++++
 tb/tb_univ_shift_reg.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/load/shift/rotate modes plus an LSB-first serialiser FSM.
// Rotate modes (100/101) are present only when UNIV_SHIFT_REG_ROTATE_EN is defined; otherwise they hold.
module univ_shift_reg #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state_o
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Per-cycle priority below reset: en low freezes everything, then set, then FSM, then mode.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = state_q;
    end else if (set) begin
      q_d     = '1;
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            q_d     = d;
            cnt_d   = '0;
            state_d = S_SHIFT;
          end else begin
            case (mode)
              MODE_HOLD: q_d = q_q;
              MODE_LOAD: q_d = d;
              MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin_l};
              MODE_SHR:  q_d = {sin_r, q_q[WIDTH-1:1]};
`ifdef UNIV_SHIFT_REG_ROTATE_EN
              MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
              MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
`else
              MODE_ROL:  q_d = q_q;
              MODE_ROR:  q_d = q_q;
`endif
              default:   q_d = q_q;
            endcase
          end
        end
        S_SHIFT: begin
          // sout already shows the next bit; the WIDTH-th shift ends the sequence.
          q_d = {sin_r, q_q[WIDTH-1:1]};
          if (cnt_q == CNT_LAST) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      q_q     <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q           = q_q;
  assign sout        = q_q[0];
  assign busy        = (state_q == S_SHIFT);
  assign done        = (state_q == S_DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8, INIT=0): mode vector table plus serialiser sequences.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       reset, set, en, sin_l, sin_r, start;
  logic [2:0] mode;
  logic [7:0] d;
  logic [7:0] q;
  logic       sout, busy, done;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

`ifdef UNIV_SHIFT_REG_ROTATE_EN
  localparam logic [7:0] ROL_81 = 8'h03;
  localparam logic [7:0] ROR_81 = 8'hC0;
`else
  localparam logic [7:0] ROL_81 = 8'h81;
  localparam logic [7:0] ROR_81 = 8'h81;
`endif

  univ_shift_reg #(.WIDTH(8), .INIT(8'h00)) dut (
    .clk(clk), .reset(reset), .set(set), .en(en), .mode(mode), .d(d),
    .sin_l(sin_l), .sin_r(sin_r), .start(start),
    .q(q), .sout(sout), .busy(busy), .done(done), .dbg_state_o(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    reset = 1'b0; set = 1'b0; en = 1'b1; mode = 3'b000;
    d = 8'h00; sin_l = 1'b0; sin_r = 1'b0; start = 1'b0;
  endtask

  // Scoreboard check
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic       en;
    logic       set;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_l;
    logic       sin_r;
    logic [7:0] exp_q;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic e, input logic s, input logic [2:0] m,
                              input logic [7:0] dd, input logic sl, input logic sr,
                              input logic [7:0] eq);
    vec_t v;
    v.en = e; v.set = s; v.mode = m; v.d = dd; v.sin_l = sl; v.sin_r = sr; v.exp_q = eq;
    return v;
  endfunction

  // LSB-first serialise of data; optional en=0 stall of stall_len cycles before bit stall_at.
  task automatic serialise(input string tag, input logic [7:0] data, input logic sr,
                           input int stall_at, input int stall_len);
    d = data; start = 1'b1; sin_r = sr; mode = 3'b000;
    step();
    start = 1'b0; mode = 3'b001; d = 8'h5A;   // mode/d must be ignored while shifting
    for (int i = 0; i < 8; i++) exp_q.push_back({7'd0, data[i]});
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        en = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          step();
          chk($sformatf("%s_stall%0d_sout", tag, k), {7'd0, sout}, exp_q[0]);
          chk($sformatf("%s_stall%0d_busy", tag, k), {7'd0, busy}, 8'd1);
        end
        en = 1'b1;
      end
      chk($sformatf("%s_bit%0d_sout", tag, i), {7'd0, sout}, exp_q.pop_front());
      chk($sformatf("%s_bit%0d_busy", tag, i), {7'd0, busy}, 8'd1);
      chk($sformatf("%s_bit%0d_done", tag, i), {7'd0, done}, 8'd0);
      step();
    end
    chk({tag, "_done_pulse"}, {7'd0, done}, 8'd1);
    chk({tag, "_done_busy"}, {7'd0, busy}, 8'd0);
    chk({tag, "_done_q"}, q, sr ? 8'hFF : 8'h00);
    step();
    chk({tag, "_after_done"}, {7'd0, done}, 8'd0);
    chk({tag, "_after_busy"}, {7'd0, busy}, 8'd0);
    chk({tag, "_after_q"}, q, sr ? 8'hFF : 8'h00);
    mode = 3'b000;
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 3'b001, 8'hA5, 0, 0, 8'hA5);
    vecs[1]  = mk(1, 0, 3'b001, 8'h81, 0, 0, 8'h81);
    vecs[2]  = mk(1, 0, 3'b010, 8'h00, 0, 0, 8'h02);
    vecs[3]  = mk(1, 0, 3'b011, 8'h00, 0, 1, 8'h81);
    vecs[4]  = mk(1, 0, 3'b100, 8'h00, 1, 1, ROL_81);
    vecs[5]  = mk(1, 0, 3'b001, 8'h81, 0, 0, 8'h81);
    vecs[6]  = mk(1, 0, 3'b101, 8'h00, 0, 0, ROR_81);
    vecs[7]  = mk(1, 0, 3'b001, 8'h3C, 0, 0, 8'h3C);
    vecs[8]  = mk(1, 0, 3'b000, 8'hFF, 1, 1, 8'h3C);
    vecs[9]  = mk(1, 0, 3'b110, 8'hFF, 1, 1, 8'h3C);
    vecs[10] = mk(1, 0, 3'b111, 8'hFF, 1, 1, 8'h3C);
    vecs[11] = mk(0, 0, 3'b001, 8'h00, 0, 0, 8'h3C);
    vecs[12] = mk(1, 1, 3'b001, 8'h00, 0, 0, 8'hFF);
    vecs[13] = mk(1, 0, 3'b010, 8'h00, 1, 0, 8'hFF);
    vecs[14] = mk(1, 0, 3'b011, 8'h00, 1, 0, 8'h7F);
    vecs[15] = mk(1, 0, 3'b010, 8'h00, 0, 1, 8'hFE);
    vecs[16] = mk(0, 1, 3'b001, 8'h00, 0, 0, 8'hFE);
    vecs[17] = mk(1, 0, 3'b001, 8'h12, 0, 0, 8'h12);

    // Reset
    drive_idle();
    reset = 1'b1; set = 1'b1; start = 1'b1;
    step();
    step();
    chk("reset_q", q, 8'h00);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    chk("reset_done", {7'd0, done}, 8'd0);
    chk("reset_state", {6'd0, dbg_state}, 8'd0);
    drive_idle();

    // Mode vector table
    for (int i = 0; i < NV; i++) begin
      en = vecs[i].en; set = vecs[i].set; mode = vecs[i].mode;
      d = vecs[i].d; sin_l = vecs[i].sin_l; sin_r = vecs[i].sin_r;
      step();
      chk($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
      chk($sformatf("vec%0d_sout", i), {7'd0, sout}, {7'd0, vecs[i].exp_q[0]});
      chk($sformatf("vec%0d_busy", i), {7'd0, busy}, 8'd0);
    end
    drive_idle();

    // start ignored while en=0
    en = 1'b0; start = 1'b1; d = 8'hC3;
    step();
    chk("start_en0_busy", {7'd0, busy}, 8'd0);
    chk("start_en0_q", q, 8'h12);
    drive_idle();

    // Plain serialise and stalled serialise
    serialise("ser", 8'hC3, 1'b0, -1, 0);
    serialise("stall", 8'hC3, 1'b1, 2, 3);

    // set mid-sequence: q all ones, no done
    d = 8'hC3; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("mid_busy_before_set", {7'd0, busy}, 8'd1);
    set = 1'b1;
    step();
    set = 1'b0;
    chk("set_mid_q", q, 8'hFF);
    chk("set_mid_busy", {7'd0, busy}, 8'd0);
    chk("set_mid_done", {7'd0, done}, 8'd0);
    for (int k = 0; k < 9; k++) begin
      step();
      chk($sformatf("set_mid_nodone%0d", k), {6'd0, busy, done}, 8'd0);
    end
    chk("set_mid_q_hold", q, 8'hFF);

    // reset mid-sequence with set and start asserted: q=INIT, no done
    d = 8'hA5; start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1; set = 1'b1; start = 1'b1;
    step();
    drive_idle();
    chk("rst_mid_q", q, 8'h00);
    chk("rst_mid_busy", {7'd0, busy}, 8'd0);
    chk("rst_mid_done", {7'd0, done}, 8'd0);
    for (int k = 0; k < 9; k++) begin
      step();
      chk($sformatf("rst_mid_nodone%0d", k), {7'd0, done}, 8'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
